pht_update_controller: RTL and testbench

- Owns a pattern history table (PHT) of 2-bit saturating branch counters. It sequences a post-reset init sweep, serves one prediction lookup per cycle and pipelines one read-modify-write counter update per cycle.
- Sits between the fetch-stage predictor (lookups) and the branch-resolve stage (updates).
- Update port and prediction port share the single table; write-to-read ordering is fixed below.

---
 rtl/pht_update_controller_pkg.sv | 14 +
 rtl/pht_counter_next.sv | 22 ++
 rtl/pht_update_controller.sv | 122 ++++++++++++
 tb/tb_pht_update_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pht_update_controller_pkg.sv
// Shared encodings for the pattern history table: 2-bit counter values and controller FSM states.
package pht_update_controller_pkg;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pht_state_t;

endpackage

// File: rtl/pht_counter_next.sv
// Saturating 2-bit branch counter step: count up on Taken, down on NotTaken, hold at the rails.
// Purely combinational, no backpressure.
module pht_counter_next
    import pht_update_controller_pkg::*;
(
    input  logic [1:0] CurrentValue,
    input  logic       Taken,
    output logic [1:0] NextValue
);

    always_comb begin
        NextValue = CurrentValue;
        if (Taken) begin
            if (CurrentValue != STRONG_T) begin
                NextValue = CurrentValue + 2'b01;
            end
        end else if (CurrentValue != STRONG_NT) begin
            NextValue = CurrentValue - 2'b01;
        end
    end

endmodule

// File: rtl/pht_update_controller.sv
// PHT owner: init sweep, one lookup/cycle (response next cycle), one pipelined counter update/cycle (write 1 cycle after accept).
// Both request ports are held off (ready low) for the whole init sweep; in RUN they are always ready.
module pht_update_controller
    import pht_update_controller_pkg::*;
#(
    parameter int         INDEX_W    = 6,
    parameter logic [1:0] INIT_VALUE = WEAK_NT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PredValid,
    input  logic [INDEX_W-1:0] PredIndex,
    output logic               PredReady,
    output logic               PredRespValid,
    output logic               PredTaken,
    input  logic               UpdValid,
    input  logic [INDEX_W-1:0] UpdIndex,
    input  logic               UpdTaken,
    output logic               UpdReady,
    output logic               InitDone
);

    localparam int DEPTH = 1 << INDEX_W;

    pht_state_t         state;
    pht_state_t         stateNext;
    logic [INDEX_W-1:0] initPtr;
    logic [1:0]         pht [DEPTH];

    logic               s2Valid;
    logic [INDEX_W-1:0] s2Index;
    logic               s2Taken;
    logic [1:0]         s2Value;
    logic [1:0]         s2Next;

    logic               predAccept;
    logic               updAccept;
    logic [1:0]         updCurrent;

    logic               wrEn;
    logic [INDEX_W-1:0] wrIndex;
    logic [1:0]         wrData;

    pht_counter_next uCounterNext (
        .CurrentValue (s2Value),
        .Taken        (s2Taken),
        .NextValue    (s2Next)
    );

    always_comb begin
        stateNext = state;
        PredReady = 1'b0;
        UpdReady  = 1'b0;
        InitDone  = 1'b0;
        case (state)
            INIT: begin
                if (&initPtr) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                PredReady = 1'b1;
                UpdReady  = 1'b1;
                InitDone  = 1'b1;
            end
            default: stateNext = INIT;
        endcase
    end

    assign predAccept = PredValid & PredReady;
    assign updAccept  = UpdValid & UpdReady;

    // A back-to-back update to the entry being written this edge must see the new value, not the table's stale copy.
    assign updCurrent = (s2Valid && (s2Index == UpdIndex)) ? s2Next : pht[UpdIndex];

    always_comb begin
        wrEn    = 1'b0;
        wrIndex = s2Index;
        wrData  = s2Next;
        if (state == INIT) begin
            wrEn    = 1'b1;
            wrIndex = initPtr;
            wrData  = INIT_VALUE;
        end else if (s2Valid) begin
            wrEn = 1'b1;
        end
    end

    // Table has no reset: the sweep rewrites every entry before anything can read it.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            pht[wrIndex] <= wrData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= INIT;
            initPtr       <= '0;
            s2Valid       <= 1'b0;
            s2Index       <= '0;
            s2Taken       <= 1'b0;
            s2Value       <= STRONG_NT;
            PredRespValid <= 1'b0;
            PredTaken     <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == INIT) begin
                initPtr <= initPtr + INDEX_W'(1);
            end
            s2Valid <= updAccept;
            if (updAccept) begin
                s2Index <= UpdIndex;
                s2Taken <= UpdTaken;
                s2Value <= updCurrent;
            end
            PredRespValid <= predAccept;
            PredTaken     <= predAccept & pht[PredIndex][1];
        end
    end

endmodule

// File: tb/tb_pht_update_controller.sv
// Bench for pht_update_controller: vector table for the RUN-mode corner cases, a reference
// table model feeding an expected-response queue, plus hand-written reset/sweep sequences.
module tb_pht_update_controller;
    import pht_update_controller_pkg::*;

    localparam int IW    = 6;
    localparam int DEPTH = 1 << IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          PredValid;
    logic [IW-1:0] PredIndex;
    logic          PredReady;
    logic          PredRespValid;
    logic          PredTaken;
    logic          UpdValid;
    logic [IW-1:0] UpdIndex;
    logic          UpdTaken;
    logic          UpdReady;
    logic          InitDone;

    typedef struct packed {
        logic v;
        logic t;
    } resp_t;

    typedef struct {
        logic          pv;
        logic [IW-1:0] pi;
        logic          uv;
        logic [IW-1:0] ui;
        logic          ut;
        logic          ev;
        logic          et;
    } vec_t;

    int      tests  = 0;
    int      failed = 0;
    resp_t   expQ[$];
    vec_t    vecs[$];
    logic [1:0]    mdl [DEPTH];
    logic          pendV;
    logic [IW-1:0] pendI;
    logic          pendT;

    pht_update_controller #(.INDEX_W(IW), .INIT_VALUE(WEAK_NT)) dut (
        .clk           (clk),
        .rst           (rst),
        .PredValid     (PredValid),
        .PredIndex     (PredIndex),
        .PredReady     (PredReady),
        .PredRespValid (PredRespValid),
        .PredTaken     (PredTaken),
        .UpdValid      (UpdValid),
        .UpdIndex      (UpdIndex),
        .UpdTaken      (UpdTaken),
        .UpdReady      (UpdReady),
        .InitDone      (InitDone)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] satNext(input logic [1:0] v, input logic t);
        if (t) return (v == 2'b11) ? 2'b11 : v + 2'b01;
        return (v == 2'b00) ? 2'b00 : v - 2'b01;
    endfunction

    function automatic vec_t mk(input logic pv, input logic [IW-1:0] pi, input logic uv,
                                input logic [IW-1:0] ui, input logic ut, input logic ev, input logic et);
        vec_t r;
        r.pv = pv; r.pi = pi; r.uv = uv; r.ui = ui; r.ut = ut; r.ev = ev; r.et = et;
        return r;
    endfunction

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %0b, want %0b", name, got, want);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = WEAK_NT;
        pendV = 1'b0;
        pendI = '0;
        pendT = 1'b0;
    endtask

    // Called at a negedge: drives one cycle, queues the expected response, checks it after the edge.
    task automatic drive(input logic pv, input logic [IW-1:0] pi, input logic uv, input logic [IW-1:0] ui,
                         input logic ut, input logic useExp, input logic ev, input logic et, input string name);
        resp_t m;
        resp_t e;
        m.v = pv;
        m.t = pv ? mdl[pi][1] : 1'b0;
        if (pendV) mdl[pendI] = satNext(mdl[pendI], pendT);
        pendV = uv; pendI = ui; pendT = ut;
        PredValid = pv; PredIndex = pi;
        UpdValid  = uv; UpdIndex  = ui; UpdTaken = ut;
        expQ.push_back(useExp ? resp_t'({ev, et}) : m);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        tests++;
        if (PredRespValid !== e.v || (e.v && PredTaken !== e.t)) begin
            failed++;
            $display("FAIL %s: resp valid/taken got %b/%b, want %b/%b", name, PredRespValid, PredTaken, e.v, e.t);
        end
        @(negedge clk);
    endtask

    // Called at a negedge with rst high: releases reset and checks the 64-edge sweep with requests pending.
    task automatic releaseAndSweep(input string tag);
        logic lowOk;
        lowOk = 1'b1;
        modelReset();
        PredValid = 1'b1; PredIndex = 6'd5;
        UpdValid  = 1'b1; UpdIndex  = 6'd0; UpdTaken = 1'b1;
        rst = 1'b0;
        for (int e = 1; e <= DEPTH; e++) begin
            @(posedge clk);
            #1;
            if (e < DEPTH) begin
                if (InitDone !== 1'b0 || PredReady !== 1'b0 || UpdReady !== 1'b0 || PredRespValid !== 1'b0)
                    lowOk = 1'b0;
            end
        end
        check({tag, " sweep held low 63 edges"}, {1'b0, lowOk}, 2'b01);
        check({tag, " InitDone after edge 64"}, {1'b0, InitDone}, 2'b01);
        check({tag, " PredReady after edge 64"}, {1'b0, PredReady}, 2'b01);
        check({tag, " UpdReady after edge 64"}, {1'b0, UpdReady}, 2'b01);
        check({tag, " no resp for INIT lookup"}, {1'b0, PredRespValid}, 2'b00);
        PredValid = 1'b0;
        UpdValid  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        PredValid = 1'b1; PredIndex = '0;
        UpdValid = 1'b0; UpdIndex = '0; UpdTaken = 1'b0;
        modelReset();

        repeat (2) @(negedge clk);
        check("reset PredReady", {1'b0, PredReady}, 2'b00);
        check("reset UpdReady", {1'b0, UpdReady}, 2'b00);
        check("reset InitDone", {1'b0, InitDone}, 2'b00);
        check("reset PredRespValid", {1'b0, PredRespValid}, 2'b00);
        check("reset PredTaken", {1'b0, PredTaken}, 2'b00);
        @(negedge clk);
        releaseAndSweep("init");

        drive(1'b1, 6'd0,  1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, "init lookup 0");
        drive(1'b1, 6'd31, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, "init lookup 31");
        drive(1'b1, 6'd63, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, "init lookup 63");
        drive(1'b0, 6'd0,  1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, "idle no resp");

        // Saturation on index 5: up to 11 and hold, then down to 00 and hold.
        vecs.push_back(mk(1, 5, 0, 0, 0, 1, 0));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0, 0, 1, 5, 1, 0, 0));
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            vecs.push_back(mk(1, 5, 0, 0, 0, 1, 1));
        end
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0, 0, 1, 5, 0, 0, 0));
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            vecs.push_back(mk(1, 5, 0, 0, 0, 1, (k == 0)));
        end
        // Back-to-back updates on index 9 must accumulate through forwarding.
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 1, 9, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 9, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 9, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 9, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 9, 0, 0, 0, 1, 0));
        // Index 12: lookup at the write edge sees the old value, one later sees the new one.
        vecs.push_back(mk(0, 0, 1, 12, 1, 0, 0));
        vecs.push_back(mk(1, 12, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 12, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 12, 1, 12, 0, 1, 1));
        vecs.push_back(mk(1, 12, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 12, 0, 0, 0, 1, 0));
        foreach (vecs[i])
            drive(vecs[i].pv, vecs[i].pi, vecs[i].uv, vecs[i].ui, vecs[i].ut, 1'b1, vecs[i].ev, vecs[i].et,
                  $sformatf("vec%0d", i));

        // Interleaved indices 0 (Taken) and 1 (NotTaken): no forwarding across indices.
        for (int k = 0; k < 6; k++)
            drive(1'b0, 6'd0, 1'b1, IW'(k % 2), (k % 2 == 0), 1'b0, 1'b0, 1'b0, "indep upd");
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, "indep idle");
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, "indep idle");
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, "indep entry0 taken");
        drive(1'b1, 6'd1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, "indep entry1 nt");
        drive(1'b0, 6'd0, 1'b1, 6'd1, 1'b1, 1'b1, 1'b0, 1'b0, "entry1 00 plus T");
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, "entry1 idle");
        drive(1'b1, 6'd1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, "entry1 now 01");
        drive(1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, "entry0 11 minus NT");
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, "entry0 idle");
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, "entry0 now 10");

        // Dense mixed traffic on a few indices, checked against the reference model.
        repeat (40) begin
            drive(1'($urandom_range(0, 1)), IW'(40 + $urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), IW'(40 + $urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'b0, 1'b0, 1'b0, "random mix");
        end

        // Reset between S1 and S2 of an update stream on index 3.
        for (int k = 0; k < 3; k++)
            drive(1'b0, 6'd0, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0, "pre-reset upd");
        rst = 1'b1;
        #1;
        check("midrst PredReady", {1'b0, PredReady}, 2'b00);
        check("midrst UpdReady", {1'b0, UpdReady}, 2'b00);
        check("midrst InitDone", {1'b0, InitDone}, 2'b00);
        check("midrst PredRespValid", {1'b0, PredRespValid}, 2'b00);
        @(negedge clk);
        releaseAndSweep("re-init");
        drive(1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, "idx3 after reset");
        drive(1'b1, 6'd9, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, "idx9 after reset");
        drive(1'b0, 6'd0, 1'b1, 6'd3, 1'b1, 1'b1, 1'b0, 1'b0, "idx3 upd after reset");
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, "idx3 idle");
        drive(1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, "idx3 01 plus T");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
